uart_rx_packer: RTL and testbench

- Sits between uart_rx (8-bit AXI-stream output) and a user AXI-stream sink.
- Packs received bytes into BYTE_WIDTH-byte words with tkeep. It is the receive-side counterpart of uart_tx's multi-byte input.
- Marks end of packet (tlast) when the line has been idle for IDLE_TIMEOUT clock cycles after the last byte.

---
 rtl/uart_rx_packer.sv | 85 ++++++++
 tb/tb_uart_rx_packer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packer.sv
// Packs the uart_rx byte stream into BYTE_WIDTH-lane AXI-stream words with tkeep,
// and closes a packet with tlast once the line has been idle for IDLE_TIMEOUT cycles.
module uart_rx_packer #(
   parameter int BYTE_WIDTH   = 2,
   parameter int IDLE_TIMEOUT = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    i_tready,
   input  logic                    i_tvalid,
   input  logic [7:0]              i_tdata,
   input  logic                    o_tready,
   output logic                    o_tvalid,
   output logic [8*BYTE_WIDTH-1:0] o_tdata,
   output logic [BYTE_WIDTH-1:0]   o_tkeep,
   output logic                    o_tlast
);
   localparam int DATA_W = 8 * BYTE_WIDTH;
   localparam int CNT_W  = $clog2(BYTE_WIDTH + 1);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BYTE_WIDTH);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

   function automatic logic [BYTE_WIDTH-1:0] keep_mask(input logic [CNT_W-1:0] cnt);
      logic [BYTE_WIDTH-1:0] m;
      for (int i = 0; i < BYTE_WIDTH; i++) m[i] = (CNT_W'(i) < cnt);
      return m;
   endfunction

   logic [DATA_W-1:0] acc_data;
   logic [CNT_W-1:0]  acc_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              out_free;
   logic              acc_full;
   logic              byte_acc;
   logic              flush;

   assign out_free = ~o_tvalid | o_tready;
   assign acc_full = (acc_cnt == CNT_FULL);
   assign i_tready = ~acc_full | out_free;
   assign byte_acc = i_tvalid & i_tready;
   assign flush    = (acc_cnt != '0) & (idle_cnt == IDLE_MAX) & ~byte_acc & out_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_data <= '0;
         acc_cnt  <= '0;
         idle_cnt <= '0;
         o_tvalid <= 1'b0;
         o_tdata  <= '0;
         o_tkeep  <= '0;
         o_tlast  <= 1'b0;
      end else begin
         if (o_tvalid & o_tready) o_tvalid <= 1'b0;

         if (byte_acc) begin
            idle_cnt <= '0;
            // A full word is only released once the next byte proves it is not the packet end.
            if (acc_full) begin
               o_tvalid <= 1'b1;
               o_tdata  <= acc_data;
               o_tkeep  <= '1;
               o_tlast  <= 1'b0;
               acc_data <= DATA_W'(i_tdata);
               acc_cnt  <= CNT_W'(1);
            end else begin
               // Starting a word clears the upper lanes so a short flush carries zeros there.
               if (acc_cnt == '0) acc_data <= DATA_W'(i_tdata);
               for (int i = 1; i < BYTE_WIDTH; i++)
                  if (acc_cnt == CNT_W'(i)) acc_data[8*i +: 8] <= i_tdata;
               acc_cnt <= acc_cnt + 1'b1;
            end
         end else if (flush) begin
            o_tvalid <= 1'b1;
            o_tdata  <= acc_data;
            o_tkeep  <= keep_mask(acc_cnt);
            o_tlast  <= 1'b1;
            acc_cnt  <= '0;
            idle_cnt <= '0;
         end else if ((acc_cnt != '0) && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: directed scenarios plus randomized byte streams scored
// against a packet-level model (gap length decides packet boundaries).
module tb_uart_rx_packer;
   localparam int BW = 2;
   localparam int TO = 8;

   typedef struct packed {
      logic [8*BW-1:0] data;
      logic [BW-1:0]   keep;
      logic            last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_tvalid = 1'b0;
   logic [7:0]      i_tdata = 8'h00;
   logic            o_tready = 1'b1;
   logic            i_tready;
   logic            o_tvalid;
   logic [8*BW-1:0] o_tdata;
   logic [BW-1:0]   o_tkeep;
   logic            o_tlast;

   int    n_chk = 0;
   int    n_fail = 0;
   beat_t mon_q[$];
   beat_t exp_q[$];

   always #5 clk = ~clk;

   uart_rx_packer #(.BYTE_WIDTH(BW), .IDLE_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
      .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
      .o_tkeep(o_tkeep), .o_tlast(o_tlast)
   );

   always @(posedge clk)
      if (!rst && o_tvalid && o_tready) mon_q.push_back({o_tdata, o_tkeep, o_tlast});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      i_tvalid = 1'b1;
      i_tdata  = b;
      for (int n = 0; n < 100; n++) begin
         #1;
         rdy = i_tready;
         tick();
         if (rdy) return;
      end
      n_chk++; n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, waited 100 cycles, required acceptance", b);
   endtask

   // Split a packet into BW-byte beats; only the final beat carries tlast.
   function automatic void model_packet(input logic [7:0] pkt[$]);
      beat_t b;
      for (int s = 0; s < pkt.size(); s += BW) begin
         b = '0;
         for (int j = 0; j < BW; j++)
            if (s + j < pkt.size()) begin
               b.data[8*j +: 8] = pkt[s+j];
               b.keep[j] = 1'b1;
            end
         b.last = (s + BW >= pkt.size());
         exp_q.push_back(b);
      end
   endfunction

   task automatic compare_queues(input string name);
      n_chk++;
      if (mon_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s_count: got %0d beats, want %0d", name, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (mon_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s_beat%0d: got %h want %h", name, i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%0b d=%h k=%b l=%0b want all zero", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      n_chk++;
      if (i_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_itready: got %0b want 1", i_tready);
      end
   endtask

   task automatic test_back_to_back();
      mon_q.delete();
      o_tready = 1'b1;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      i_tvalid = 1'b0;
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h2211, 2'b11, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_word: got v=%0b d=%h k=%b l=%0b want v=1 d=2211 k=11 l=0", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      repeat (TO) tick();
      n_chk++;
      if (o_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_early_flush: got v=%0b want 0 before timeout", o_tvalid);
      end
      tick();
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h0033, 2'b01, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_flush: got v=%0b d=%h k=%b l=%0b want v=1 d=0033 k=01 l=1", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      tick();
      exp_q.delete();
      exp_q.push_back({16'h2211, 2'b11, 1'b0});
      exp_q.push_back({16'h0033, 2'b01, 1'b1});
      compare_queues("b2b");
   endtask

   task automatic test_single_word();
      mon_q.delete();
      send_byte(8'hA1); send_byte(8'hA2);
      i_tvalid = 1'b0;
      repeat (TO) tick();
      n_chk++;
      if (o_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL word_held: got v=%0b want 0 before timeout", o_tvalid);
      end
      tick();
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'hA2A1, 2'b11, 1'b1}) begin
         n_fail++;
         $display("FAIL word_flush: got v=%0b d=%h k=%b l=%0b want v=1 d=a2a1 k=11 l=1", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      repeat (15) tick();
      exp_q.delete();
      exp_q.push_back({16'hA2A1, 2'b11, 1'b1});
      compare_queues("word");
   endtask

   task automatic test_backpressure();
      mon_q.delete();
      o_tready = 1'b0;
      for (int b = 1; b <= 4; b++) send_byte(8'(b));
      i_tvalid = 1'b1;
      i_tdata  = 8'h05;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_chk++;
         if (i_tready !== 1'b0 || {o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h0201, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got rdy=%0b v=%0b d=%h k=%b l=%0b want rdy=0 v=1 d=0201 k=11 l=0",
                     c, i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast);
         end
         tick();
      end
      o_tready = 1'b1;
      #1;
      n_chk++;
      if (i_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_rdy: got %0b want 1", i_tready);
      end
      tick();
      i_tvalid = 1'b0;
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h0403, 2'b11, 1'b0}) begin
         n_fail++;
         $display("FAIL bp_next_word: got v=%0b d=%h k=%b l=%0b want v=1 d=0403 k=11 l=0", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      repeat (TO) tick();
      tick();
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h0005, 2'b01, 1'b1}) begin
         n_fail++;
         $display("FAIL bp_flush: got v=%0b d=%h k=%b l=%0b want v=1 d=0005 k=01 l=1", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      tick();
      exp_q.delete();
      exp_q.push_back({16'h0201, 2'b11, 1'b0});
      exp_q.push_back({16'h0403, 2'b11, 1'b0});
      exp_q.push_back({16'h0005, 2'b01, 1'b1});
      compare_queues("bp");
   endtask

   task automatic test_accept_beats_timeout();
      mon_q.delete();
      o_tready = 1'b1;
      send_byte(8'h44);
      i_tvalid = 1'b0;
      repeat (TO) tick();
      send_byte(8'h55);
      i_tvalid = 1'b0;
      n_chk++;
      if (o_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL race_no_flush: got v=%0b d=%h l=%0b want v=0", o_tvalid, o_tdata, o_tlast);
      end
      repeat (TO) tick();
      tick();
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h5544, 2'b11, 1'b1}) begin
         n_fail++;
         $display("FAIL race_flush: got v=%0b d=%h k=%b l=%0b want v=1 d=5544 k=11 l=1", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      tick();
      exp_q.delete();
      exp_q.push_back({16'h5544, 2'b11, 1'b1});
      compare_queues("race");
   endtask

   task automatic test_stall_timeout();
      mon_q.delete();
      o_tready = 1'b0;
      send_byte(8'h81); send_byte(8'h82); send_byte(8'h83);
      i_tvalid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_chk++;
         if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h8281, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got v=%0b d=%h k=%b l=%0b want v=1 d=8281 k=11 l=0",
                     c, o_tvalid, o_tdata, o_tkeep, o_tlast);
         end
      end
      o_tready = 1'b1;
      tick();
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h0083, 2'b01, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_flush: got v=%0b d=%h k=%b l=%0b want v=1 d=0083 k=01 l=1", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      tick();
      exp_q.delete();
      exp_q.push_back({16'h8281, 2'b11, 1'b0});
      exp_q.push_back({16'h0083, 2'b01, 1'b1});
      compare_queues("stall");
   endtask

   task automatic test_reset_mid();
      o_tready = 1'b0;
      send_byte(8'h91); send_byte(8'h92); send_byte(8'h93);
      i_tvalid = 1'b0;
      n_chk++;
      if (o_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_setup: got v=%0b want 1", o_tvalid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_chk++;
      if ({o_tvalid, i_tready, o_tdata, o_tkeep, o_tlast} !== {1'b0, 1'b1, 16'h0000, 2'b00, 1'b0}) begin
         n_fail++;
         $display("FAIL rstmid_state: got v=%0b rdy=%0b d=%h k=%b l=%0b want v=0 rdy=1 d=0000 k=00 l=0",
                  o_tvalid, i_tready, o_tdata, o_tkeep, o_tlast);
      end
      mon_q.delete();
      o_tready = 1'b1;
      send_byte(8'h66); send_byte(8'h77);
      i_tvalid = 1'b0;
      repeat (TO + 1) tick();
      n_chk++;
      if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, 16'h7766, 2'b11, 1'b1}) begin
         n_fail++;
         $display("FAIL rstmid_flush: got v=%0b d=%h k=%b l=%0b want v=1 d=7766 k=11 l=1", o_tvalid, o_tdata, o_tkeep, o_tlast);
      end
      tick();
      exp_q.delete();
      exp_q.push_back({16'h7766, 2'b11, 1'b1});
      compare_queues("rstmid");
   endtask

   task automatic test_random_gaps();
      int         gap_set[10] = '{0, 0, 0, 1, 2, 3, 7, 8, 9, 12};
      logic [7:0] bytes[$];
      int         gaps[$];
      logic [7:0] pkt[$];
      mon_q.delete();
      exp_q.delete();
      o_tready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bytes.push_back(8'($urandom));
         gaps.push_back(gap_set[$urandom_range(0, 9)]);
      end
      // More than TO idle cycles between accepted bytes ends a packet.
      for (int i = 0; i < 60; i++) begin
         if (i > 0 && gaps[i] > TO) begin
            model_packet(pkt);
            pkt.delete();
         end
         pkt.push_back(bytes[i]);
      end
      model_packet(pkt);
      for (int i = 0; i < 60; i++) begin
         if (gaps[i] > 0) begin
            i_tvalid = 1'b0;
            repeat (gaps[i]) tick();
         end
         send_byte(bytes[i]);
      end
      i_tvalid = 1'b0;
      repeat (TO + 5) tick();
      compare_queues("rand");
   endtask

   task automatic test_random_backpressure();
      logic [7:0] bytes[$];
      beat_t      snap;
      logic       stalled;
      logic       took;
      int         idx;
      int         gap;
      int         cycles;
      mon_q.delete();
      exp_q.delete();
      for (int i = 0; i < 40; i++) bytes.push_back(8'($urandom));
      model_packet(bytes);
      idx = 0; gap = $urandom_range(0, 2); cycles = 0; stalled = 1'b0; snap = '0;
      while (idx < 40 && cycles < 2000) begin
         if (stalled) begin
            n_chk++;
            if (o_tvalid !== 1'b1 || {o_tdata, o_tkeep, o_tlast} !== snap) begin
               n_fail++;
               $display("FAIL rbp_stable: got v=%0b beat=%h want v=1 beat=%h", o_tvalid, {o_tdata, o_tkeep, o_tlast}, snap);
            end
         end
         o_tready = 1'($urandom_range(0, 1));
         if (gap > 0) i_tvalid = 1'b0;
         else begin
            i_tvalid = 1'b1;
            i_tdata  = bytes[idx];
         end
         #1;
         took    = i_tvalid && i_tready;
         stalled = o_tvalid && !o_tready;
         snap    = {o_tdata, o_tkeep, o_tlast};
         tick();
         cycles++;
         if (gap > 0) gap--;
         else if (took) begin
            idx++;
            gap = $urandom_range(0, 2);
         end
      end
      n_chk++;
      if (idx != 40) begin
         n_fail++;
         $display("FAIL rbp_progress: got %0d bytes accepted, want 40", idx);
      end
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      repeat (TO + 5) tick();
      compare_queues("rbp");
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_single_word();
      test_backpressure();
      test_accept_beats_timeout();
      test_stall_timeout();
      test_reset_mid();
      test_random_gaps();
      test_random_backpressure();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
